// File: rtl/irrigation_zone_scheduler.sv
// Round-robin irrigation valve scheduler with tank refill hysteresis and fill-timeout fault.
// Timers advance only on slow-clock tick pulses; every output is a flop.
module irrigation_zone_scheduler #(
  parameter int ZONES        = 4,
  parameter int LEVEL_W      = 3,
  parameter int LOW_LEVEL    = 1,
  parameter int HIGH_LEVEL   = 6,
  parameter int DWELL_TICKS  = 5,
  parameter int FILL_TIMEOUT = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [LEVEL_W-1:0]         water_level,
  input  logic [ZONES-1:0]           zone_enable,
  input  logic [ZONES-1:0]           zone_mode,
  output logic [ZONES-1:0]           valve,
  output logic                       sprinkler,
  output logic                       dripper,
  output logic                       watering,
  output logic                       filling,
  output logic [$clog2(ZONES)-1:0]   active_zone,
  output logic                       fault,
  output logic [1:0]                 state
);

  localparam int ZW      = $clog2(ZONES);
  localparam int CNT_MAX = (DWELL_TICKS > FILL_TIMEOUT) ? DWELL_TICKS : FILL_TIMEOUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATER = 2'd1,
    FILL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ZW-1:0]   zone_q, zone_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic [ZONES-1:0] valve_q, valve_d;
  logic            sprinkler_q, sprinkler_d;
  logic            dripper_q, dripper_d;
  logic            watering_q, watering_d;
  logic            filling_q, filling_d;
  logic            fault_q, fault_d;
  logic            level_low_s, level_high_s, dwell_done_s;
  logic [ZW:0]     pick_s;

  // First enabled zone searching from start (or the one after it), wrapping; MSB = found.
  function automatic logic [ZW:0] pick_zone(input logic [ZONES-1:0] en,
                                            input logic [ZW-1:0]    start,
                                            input logic             skip_start);
    logic [ZW:0] res;
    int          idx;
    res = '0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      idx = (int'(start) + i + int'(skip_start)) % ZONES;
      if (en[ZW'(idx)]) begin
        res = {1'b1, ZW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state, counter and output decode.
  always_comb begin
    state_d      = state_q;
    zone_d       = zone_q;
    dwell_d      = dwell_q;
    fill_d       = fill_q;
    pick_s       = '0;
    level_low_s  = (water_level <= LEVEL_W'(LOW_LEVEL));
    level_high_s = (water_level >= LEVEL_W'(HIGH_LEVEL));
    dwell_done_s = tick && (dwell_q == CW'(DWELL_TICKS - 1));

    case (state_q)
      IDLE: begin
        if (level_low_s) begin
          state_d = FILL;
          fill_d  = '0;
        end else begin
          pick_s = pick_zone(zone_enable, zone_q, 1'b0);
          if (pick_s[ZW]) begin
            state_d = WATER;
            zone_d  = pick_s[ZW-1:0];
            dwell_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WATER: begin
        // Low level wins over expiry/disable; the zone restarts its full dwell afterwards.
        if (level_low_s) begin
          state_d = FILL;
          dwell_d = '0;
          fill_d  = '0;
        end else if (!zone_enable[zone_q] || dwell_done_s) begin
          pick_s  = pick_zone(zone_enable, zone_q, 1'b1);
          dwell_d = '0;
          if (pick_s[ZW]) begin
            zone_d = pick_s[ZW-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (tick) begin
          dwell_d = dwell_q + CW'(1);
        end else begin
          dwell_d = dwell_q;
        end
      end
      FILL: begin
        if (level_high_s) begin
          state_d = IDLE;
          fill_d  = '0;
        end else if (tick && (fill_q == CW'(FILL_TIMEOUT - 1))) begin
          state_d = FAULT;
        end else if (tick) begin
          fill_d = fill_q + CW'(1);
        end else begin
          fill_d = fill_q;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase

    watering_d  = (state_d == WATER);
    filling_d   = (state_d == FILL);
    fault_d     = (state_d == FAULT);
    valve_d     = watering_d ? (ZONES'(1) << zone_d) : '0;
    sprinkler_d = watering_d && zone_mode[zone_d];
    dripper_d   = watering_d && !zone_mode[zone_d];
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      zone_q      <= '0;
      dwell_q     <= '0;
      fill_q      <= '0;
      valve_q     <= '0;
      sprinkler_q <= 1'b0;
      dripper_q   <= 1'b0;
      watering_q  <= 1'b0;
      filling_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      zone_q      <= zone_d;
      dwell_q     <= dwell_d;
      fill_q      <= fill_d;
      valve_q     <= valve_d;
      sprinkler_q <= sprinkler_d;
      dripper_q   <= dripper_d;
      watering_q  <= watering_d;
      filling_q   <= filling_d;
      fault_q     <= fault_d;
    end
  end

  assign valve       = valve_q;
  assign sprinkler   = sprinkler_q;
  assign dripper     = dripper_q;
  assign watering    = watering_q;
  assign filling     = filling_q;
  assign fault       = fault_q;
  assign active_zone = zone_q;
  assign state       = state_q;

endmodule

// File: doc/irrigation_zone_scheduler.md
Name: irrigation_zone_scheduler

Overview:
- Parametrised successor to the fixed two-output irrigation/tank control path.
- Drives ZONES independent valves round-robin, each for a programmable dwell time.
- Per-zone sprinkler/dripper mode selection.
- Tank refill with hysteresis and a fill-timeout fault latch.
- Sits between the switch/level inputs and the matrix display path. Runs on the fast clock and advances timers only on slow-clock tick pulses.

Parameters:
- ZONES, 4, number of irrigation zones (2..8)
- LEVEL_W, 3, width of the water_level input
- LOW_LEVEL, 1, level at or below which watering stops and filling starts
- HIGH_LEVEL, 6, level at or above which filling stops; must satisfy LOW_LEVEL < HIGH_LEVEL < 2**LEVEL_W
- DWELL_TICKS, 5, tick pulses each zone is watered per visit (>=1)
- FILL_TIMEOUT, 20, tick pulses allowed in FILL before fault (>=1)

Ports:
- clock  in  1  system clock (fast clock)
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle enable pulse, synchronous to clock, derived from the slow clock
- water_level  in  LEVEL_W  current tank level, unsigned
- zone_enable  in  ZONES  bit i=1 allows zone i to be scheduled
- zone_mode  in  ZONES  bit i=1 selects sprinkler for zone i, 0 selects dripper
- valve  out  ZONES  one-hot open valve; all zero when not watering
- sprinkler  out  1  watering with a sprinkler-mode zone
- dripper  out  1  watering with a dripper-mode zone
- watering  out  1  state is WATER
- filling  out  1  state is FILL
- active_zone  out  clog2(ZONES)  zone pointer
- fault  out  1  fill-timeout fault latched
- state  out  2  IDLE=0, WATER=1, FILL=2, FAULT=3

Behaviour:

Reset (async, any state):
- state=IDLE, active_zone=0.
- valve, sprinkler, dripper, watering, filling and fault = 0.
- Dwell and fill counters = 0.

Registering:
- All outputs are registered and change on the same edge as state.
- Conditions are evaluated every clock; counters advance only when tick=1.

IDLE:
- level<=LOW_LEVEL -> FILL.
- Else, if any zone is enabled -> WATER. Zone = first enabled zone at or after active_zone, wrapping. Dwell counter = 0.
- Else stay in IDLE.

WATER:
- valve = one-hot of active_zone. sprinkler = zone_mode[active_zone]. dripper = the inverse of zone_mode[active_zone].
- Priority 1: level<=LOW_LEVEL -> FILL.
  - Pointer is unchanged and the dwell counter clears, so the zone restarts its full dwell after refill.
  - Takes precedence over a simultaneous dwell expiry or disable.
- Priority 2: either of the following advances the zone:
  - zone_enable[active_zone]=0, or
  - tick=1 with the dwell counter equal to DWELL_TICKS-1.
- Advancing means:
  - Move to the next enabled zone strictly after active_zone, wrapping. This may be the same zone if it is the only one enabled.
  - Dwell counter clears.
  - If no zone is enabled, go to IDLE and keep the pointer.
- A simultaneous disable and expiry advances exactly once.
- Otherwise, a tick increments the dwell counter.
- Each zone is therefore open for exactly DWELL_TICKS tick pulses. It closes on the edge that samples the last tick.

FILL:
- filling=1, valve=0.
- level>=HIGH_LEVEL -> IDLE, fill counter clears.
- Else, tick with fill counter equal to FILL_TIMEOUT-1 -> FAULT.
- Else, a tick increments the fill counter.
- Levels strictly between the thresholds keep filling (hysteresis).

FAULT:
- fault=1; all valves, sprinkler, dripper and filling = 0.
- Absorbing: only reset exits, regardless of level or enables.

Width rules:
- Level comparisons are unsigned.
- Counters are sized to hold max(DWELL_TICKS, FILL_TIMEOUT)-1 and never wrap.

Invariants:
- At most one valve bit set.
- valve!=0 only in WATER.
- sprinkler and dripper are mutually exclusive.
- watering and filling are never both 1.

Test Plan:
1. Reset mid-WATER: ZONES=4, level=4, enable=1111, raise reset between clock edges -> outputs 0 and state=0 immediately, without waiting for a clock edge. After release -> WATER zone 0 on the first edge.
2. Round-robin: enable=1011, level=4, DWELL_TICKS=5, tick every 4 clocks -> valve sequence 0001, 0010, 1000, 0001. Each zone lasts exactly 5 ticks (20 clocks) and zone 2 is never opened.
3. Low level mid-dwell: zone 1 active after 2 ticks, level drops to 1 -> next edge state=FILL, valve=0000, filling=1, active_zone=1. Level rises to 5 -> stays FILL. Level 6 -> IDLE, then WATER zone 1 for a full 5 ticks.
4. Fill timeout: FILL_TIMEOUT=20, level held at 2 -> fault=1 and state=3 on the 20th tick. Level 7 afterwards -> remains FAULT until reset.
5. Modes: zone_mode=0010, enable=0011 -> zone 0 gives dripper=1 and sprinkler=0; zone 1 gives sprinkler=1 and dripper=0. Never both 1.
6. Disable during dwell: zone 2 active, clear zone_enable[2] -> next edge advances to zone 3. Then clear all enables -> IDLE with valve=0000 and active_zone=3 retained.
